// File: rtl/line_tool_if.sv
// rtl/line_tool_if.sv - cursor/button inputs and canvas pixel-write outputs of the line tool
interface line_tool_if #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int COLOR_WIDTH = 8
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                   enable;
  logic [XW-1:0]          cursor_x;
  logic [YW-1:0]          cursor_y;
  logic [COLOR_WIDTH-1:0] input_color;
  logic [XW-1:0]          pixel_x;
  logic [YW-1:0]          pixel_y;
  logic [COLOR_WIDTH-1:0] pixel_color;
  logic                   pixel_valid;
  logic                   busy;

  // Mouse/colour source side
  modport master (
    output enable, cursor_x, cursor_y, input_color,
    input  pixel_x, pixel_y, pixel_color, pixel_valid, busy
  );

  // Line tool side
  modport slave (
    input  enable, cursor_x, cursor_y, input_color,
    output pixel_x, pixel_y, pixel_color, pixel_valid, busy
  );
endinterface

// File: rtl/line_tool.sv
// rtl/line_tool.sv - two-point line tool: press/release anchors, Bresenham rasteriser, one pixel per clock
module line_tool #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int COLOR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  line_tool_if.slave  bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = ((XW > YW) ? XW : YW) + 3;

  typedef enum logic [1:0] {IDLE, ARMED, SETUP, DRAW} state_t;

  state_t                  state_q, state_d;
  logic                    en_q;      // registered enable (enable_d)
  logic                    init_q;    // low only on the first cycle out of reset
  logic [XW-1:0]           x0_q, x1_q;
  logic [YW-1:0]           y0_q, y1_q;
  logic [COLOR_WIDTH-1:0]  col_q;
  logic signed [AW-1:0]    dx_q, dy_q, err_q;
  logic                    sx_neg_q, sy_neg_q;
  logic [XW-1:0]           pixel_x_q;
  logic [YW-1:0]           pixel_y_q;
  logic [COLOR_WIDTH-1:0]  pixel_color_q;
  logic                    pixel_valid_q, busy_q;

  // The pixel registers double as the Bresenham cursor (cx, cy) while drawing.
  logic                    press, at_end, step_x, step_y;
  logic [XW-1:0]           dx_abs;
  logic [YW-1:0]           dy_abs;
  logic signed [AW-1:0]    dx_c, dy_c, e2, err_d;

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
    return (32'(v) >= WIDTH) ? XW'(WIDTH - 1) : v;
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
    return (32'(v) >= HEIGHT) ? YW'(HEIGHT - 1) : v;
  endfunction

  // A button already held when reset is released must not count as a press.
  assign press  = bus.enable & ~en_q & init_q;
  assign at_end = (pixel_x_q == x1_q) && (pixel_y_q == y1_q);

  assign dx_abs = (x1_q > x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
  assign dy_abs = (y1_q > y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
  assign dx_c   = $signed(AW'(dx_abs));
  assign dy_c   = -$signed(AW'(dy_abs));

  // Both axis decisions use the pre-update error term.
  assign e2     = err_q <<< 1;
  assign step_x = (e2 >= dy_q);
  assign step_y = (e2 <= dx_q);
  assign err_d  = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: press arms, release sets up, drawing ends on the endpoint
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (press)       state_d = ARMED;
      ARMED:   if (!bus.enable) state_d = SETUP;
      SETUP:                    state_d = DRAW;
      DRAW:    if (at_end)      state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Endpoint capture, line setup and per-pixel Bresenham stepping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q          <= 1'b0;
      init_q        <= 1'b0;
      x0_q          <= '0;
      y0_q          <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      col_q         <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      err_q         <= '0;
      sx_neg_q      <= 1'b0;
      sy_neg_q      <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_color_q <= '0;
      pixel_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      en_q   <= bus.enable;
      init_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (press) begin
            x0_q <= clamp_x(bus.cursor_x);
            y0_q <= clamp_y(bus.cursor_y);
          end
        end
        ARMED: begin
          if (!bus.enable) begin
            x1_q   <= clamp_x(bus.cursor_x);
            y1_q   <= clamp_y(bus.cursor_y);
            col_q  <= bus.input_color;
            busy_q <= 1'b1;
          end
        end
        SETUP: begin
          dx_q          <= dx_c;
          dy_q          <= dy_c;
          err_q         <= dx_c + dy_c;
          sx_neg_q      <= !(x0_q < x1_q);
          sy_neg_q      <= !(y0_q < y1_q);
          pixel_x_q     <= x0_q;
          pixel_y_q     <= y0_q;
          pixel_color_q <= col_q;
          pixel_valid_q <= 1'b1;
        end
        DRAW: begin
          if (at_end) begin
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end else begin
            err_q <= err_d;
            if (step_x) pixel_x_q <= sx_neg_q ? pixel_x_q - XW'(1) : pixel_x_q + XW'(1);
            if (step_y) pixel_y_q <= sy_neg_q ? pixel_y_q - YW'(1) : pixel_y_q + YW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pixel_x     = pixel_x_q;
  assign bus.pixel_y     = pixel_y_q;
  assign bus.pixel_color = pixel_color_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.busy        = busy_q;
endmodule

// File: doc/line_tool.md
# line_tool

Two-point straight-line drawing tool that sits upstream of `drawing_canvas`, in parallel with `freehand_tool`. It takes the mouse cursor position and button, anchors a start point on press, and captures the end point on release. It then rasterises the segment with Bresenham's algorithm, emitting one pixel per clock on `pixel_x`/`pixel_y`/`pixel_color` with a `pixel_valid` qualifier for the canvas write port.

## Interface
- `WIDTH`, 640, canvas width in pixels; x ports are `$clog2(WIDTH)` bits.
- `HEIGHT`, 480, canvas height in pixels; y ports are `$clog2(HEIGHT)` bits.
- Color width is `COLOR_WIDTH` from `common.sv`.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  tool button (mouse left); high = pressed. Synchronous to `clk`, already filtered.
- `cursor_x`  in  `$clog2(WIDTH)`  cursor column.
- `cursor_y`  in  `$clog2(HEIGHT)`  cursor row.
- `input_color`  in  `COLOR_WIDTH`  currently selected color.
- `pixel_x`  out  `$clog2(WIDTH)`  rasterised pixel column.
- `pixel_y`  out  `$clog2(HEIGHT)`  rasterised pixel row.
- `pixel_color`  out  `COLOR_WIDTH`  color of the line being drawn.
- `pixel_valid`  out  1  high exactly on cycles that carry a line pixel.
- `busy`  out  1  high while in SETUP or DRAW.

Clock/reset: one clock; reset is asynchronous and active-low.

## Operation
FSM states: IDLE, ARMED, SETUP, DRAW.
- **IDLE**
  - `enable` high while the registered `enable_d` is low (rising edge): latch `x0`/`y0` from the cursor, go to ARMED.
  - `enable` already high on reset exit counts as no edge; the FSM waits for release and a fresh press.
- **ARMED**
  - `enable` low (release): latch `x1`/`y1` from the cursor and `col` from `input_color`, go to SETUP.
  - While `enable` stays high, remain in ARMED.
- **SETUP** (one cycle), then go to DRAW:
  - `dx = |x1-x0|`, `dy = -|y1-y0|`
  - `sx = (x0<x1) ? +1 : -1`, `sy = (y0<y1) ? +1 : -1`
  - `err = dx+dy`, `(cx,cy) = (x0,y0)`
- **DRAW**: each cycle output `(cx,cy,col)` with `pixel_valid=1`.
  - If `cx==x1 && cy==y1`, go to IDLE.
  - Else compute `e2 = 2*err`.
  - If `e2 >= dy`: `err += dy`, `cx += sx`.
  - If `e2 <= dx`: `err += dx`, `cy += sy`.
  - Both updates use the pre-update `err` and `e2`, and both may apply in the same cycle.
- Arithmetic: `err`/`e2`/`dx`/`dy` are signed, `max($clog2(WIDTH),$clog2(HEIGHT))+3` bits; no overflow for any in-range endpoints.
- Coordinate clamping: cursor values at or above `WIDTH`/`HEIGHT` are clamped to `WIDTH-1`/`HEIGHT-1` when latched.
- `enable` edges during SETUP/DRAW are ignored and not queued. After DRAW, a new line needs a fresh rising edge seen in IDLE.
- Pixel count per line is `max(dx,|dy|)+1`. Press and release at the same point gives exactly one pixel.
- `input_color` changes after release do not affect a line in progress.

## Timing
- Reset values: `pixel_x=0`, `pixel_y=0`, `pixel_color=0`, `pixel_valid=0`, `busy=0`, state=IDLE, `enable_d=0`.
- All outputs are registered.
- Latency: if the edge at cycle N samples the release, SETUP is active at N+1 and the first valid pixel is presented at N+2. Pixels then come back-to-back, one per cycle, with no gaps.
- `busy` rises together with SETUP and falls on the cycle after the last valid pixel.
- Between lines, `pixel_x`/`pixel_y`/`pixel_color` hold their last values; only `pixel_valid` drops.
- Reset asserted mid-line: all outputs and state return to reset values immediately (asynchronously), and the partial line is abandoned.

## Test plan
Bench parameters: `WIDTH=8`, `HEIGHT=8`.
1. **Reset behaviour.** Hold `reset_n=0` with `enable=1`, then release it -> all outputs 0. No line starts until `enable` drops and rises again.
2. **Single point.** Press and release at (3,3), color 2 -> exactly one valid cycle carrying (3,3,2), two cycles after release is sampled; `busy` high for 2 cycles.
3. **Horizontal line.** Press (2,3), release (6,3) -> valid pixels (2,3),(3,3),(4,3),(5,3),(6,3) on consecutive cycles, then `pixel_valid=0`.
4. **Steep negative line.** Press (5,7), release (4,2) -> exact sequence (5,7),(5,6),(5,5),(4,4),(4,3),(4,2). Diagonal (0,0)->(3,3) -> (0,0),(1,1),(2,2),(3,3).
5. **Edges during a line.** During the line (0,0)->(7,0), toggle `enable` and change `input_color` -> all 8 pixels keep the latched color, and no second line starts.
6. **Reset mid-line.** Assert `reset_n=0` at the 3rd pixel of (0,0)->(7,7) -> `pixel_valid`/`busy` drop immediately, state returns to IDLE, and a subsequent press/release draws normally.
